vga_timing: RTL

- Generates the VGA raster: hsync, vsync, pixel coordinates vgax/vgay, an active-video flag and the once-per-frame update pulse.
- Drives every pixel-source block, such as paddle and ball, which compare vgax/vgay against their own position and return a pixel bit.
- Standard 640x480@60 timing, with one pixel every CLK_DIV clck cycles.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_mod_counter.sv | 32 +++
 rtl/vga_timing.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing defaults, derived totals/sync windows and coordinate types.
// Pure constants and types; no logic, no latency.
package vga_pkg;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int HW = 10;
    localparam int VW = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL     = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL     = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HSYNC_END   = HSYNC_START + DEF_H_SYNC;
    localparam int VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VSYNC_END   = VSYNC_START + DEF_V_SYNC;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } coord_t;
endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable, wrap carry-out and reset value; o_nxt is the value loaded on this edge.
// Zero latency: o_nxt/o_wrap are combinational from the current count and i_en; no backpressure.
module vga_mod_counter #(
    parameter int W       = 10,
    parameter int N       = 800,
    parameter int RST_VAL = 0
) (
    input  logic         clck,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_nxt,
    output logic         o_wrap
);
    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(N - 1));
    assign o_wrap = i_en && w_last;

    always_comb begin
        o_nxt = r_cnt;
        if (i_en)
            o_nxt = w_last ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= W'(RST_VAL);
        else
            r_cnt <= o_nxt;
    end
endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: syncs, coordinates, active flag, per-frame update; optional frame counter via VGA_FRAME_CNT_EN.
// Outputs registered from next h/v on the tick edge (zero counter-to-output latency); free-running, no backpressure.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic          clck,
    input  logic          rst_n,
    output logic          pix_stb,
    output logic [XW-1:0] vgax,
    output logic [YW-1:0] vgay,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          update
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]   frame
`endif
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] L_HACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] L_HS_S  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] L_HS_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] L_VACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] L_VS_S  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] L_VS_E  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic          w_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [4:0]    w_div_nxt;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_unused;
    coord_t        w_pos;
    logic          w_act;
    logic          w_hs;
    logic          w_vs;
    logic          w_upd;

    logic          r_pix_stb;
    coord_t        r_pos;
    logic          r_active;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_update;

    vga_mod_counter #(.W(5), .N(CLK_DIV), .RST_VAL(0)) u_div (
        .clck(clck), .rst_n(rst_n), .i_en(1'b1), .o_nxt(w_div_nxt), .o_wrap(w_tick)
    );

    // Reset to the last blanking pixel so the first tick lands on (0,0).
    vga_mod_counter #(.W(HW), .N(HT), .RST_VAL(HT - 1)) u_h (
        .clck(clck), .rst_n(rst_n), .i_en(w_tick), .o_nxt(w_h_nxt), .o_wrap(w_h_wrap)
    );

    vga_mod_counter #(.W(VW), .N(VT), .RST_VAL(VT - 1)) u_v (
        .clck(clck), .rst_n(rst_n), .i_en(w_h_wrap), .o_nxt(w_v_nxt), .o_wrap(w_v_wrap)
    );

    assign w_unused = ^{w_div_nxt, w_v_wrap};

    assign w_act   = (w_h_nxt < L_HACT) && (w_v_nxt < L_VACT);
    assign w_pos.x = (w_h_nxt < L_HACT) ? w_h_nxt : '0;
    assign w_pos.y = (w_v_nxt < L_VACT) ? w_v_nxt[YW-1:0] : '0;
    assign w_hs    = !((w_h_nxt >= L_HS_S) && (w_h_nxt < L_HS_E));
    assign w_vs    = !((w_v_nxt >= L_VS_S) && (w_v_nxt < L_VS_E));
    assign w_upd   = (w_h_nxt == '0) && (w_v_nxt == L_VACT);

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_stb <= 1'b0;
            r_pos     <= '0;
            r_active  <= 1'b0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_update  <= 1'b0;
        end else begin
            r_pix_stb <= w_tick;
            r_pos     <= w_pos;
            r_active  <= w_act;
            r_hsync   <= w_hs;
            r_vsync   <= w_vs;
            r_update  <= w_upd;
        end
    end

    assign pix_stb = r_pix_stb;
    assign vgax    = r_pos.x;
    assign vgay    = r_pos.y;
    assign active  = r_active;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
    assign update  = r_update;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame;

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n)
            r_frame <= '0;
        else if (w_upd && !r_update)
            r_frame <= r_frame + 1'b1;
    end

    assign frame = r_frame;
`endif
endmodule
